mem_resp_pipe: RTL and testbench

MEM_RESP_PIPE -- requirements
Module: mem_resp_pipe

---
 rtl/mem_resp_pipe.sv | 88 ++++++++
 tb/tb_mem_resp_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: word memory with a fixed-latency, fully pipelined read-return path.
// Define MEM_RESP_HAZARD_CHK_EN to add the write-over-in-flight-read hazard flag.
module mem_resp_pipe #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic [15:0] resp_addr,
   output logic        busy
`ifdef MEM_RESP_HAZARD_CHK_EN
   ,
   output logic        hazard
`endif
);

   localparam int WORDS = 2 ** DEPTH_LOG2;

   logic [15:0]           mem [WORDS];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  wr_accept;
   logic                  rd_accept;
   logic [LATENCY-1:0]    pipe_valid;
   logic [15:0]           pipe_data [LATENCY];
   logic [15:0]           pipe_addr [LATENCY];

   assign word_idx  = addr[DEPTH_LOG2:1];
   assign wr_accept = enable && wr && !rst;
   assign rd_accept = enable && !wr && !rst;

   // Storage is deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[word_idx] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid <= {pipe_valid[LATENCY-2:0], rd_accept};
      end
   end

   // Stage 0 snapshots the word at the accept edge; later writes cannot alter it.
   always_ff @(posedge clk) begin
      pipe_data[0] <= mem[word_idx];
      pipe_addr[0] <= addr;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_data[i] <= pipe_data[i-1];
         pipe_addr[i] <= pipe_addr[i-1];
      end
   end

   assign data_valid = pipe_valid[LATENCY-1];
   assign data_out   = data_valid ? pipe_data[LATENCY-1] : 16'h0000;
   assign resp_addr  = data_valid ? pipe_addr[LATENCY-1] : 16'h0000;
   assign busy       = |pipe_valid;

`ifdef MEM_RESP_HAZARD_CHK_EN
   logic hazard_match;

   always_comb begin
      hazard_match = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         if (pipe_valid[i] && (pipe_addr[i][DEPTH_LOG2:1] == word_idx)) begin
            hazard_match = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hazard <= 1'b0;
      end else begin
         hazard <= wr_accept && hazard_match;
      end
   end
`endif

endmodule

// File: tb/tb_mem_resp_pipe.sv
// tb_mem_resp_pipe: table-driven directed vectors plus hand-written multi-cycle sequences
// for mem_resp_pipe (LATENCY=4 main instance, LATENCY=2 secondary instance).
module tb_mem_resp_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic [15:0] resp_addr;
   logic        busy;

   logic        en2;
   logic        wr2;
   logic [15:0] addr2;
   logic [15:0] din2;
   logic [15:0] data_out2;
   logic        data_valid2;
   logic [15:0] resp_addr2;
   logic        busy2;

`ifdef MEM_RESP_HAZARD_CHK_EN
   logic        hazard;
   logic        hazard2;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   mem_resp_pipe #(.DEPTH_LOG2(8), .LATENCY(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .resp_addr  (resp_addr),
      .busy       (busy)
`ifdef MEM_RESP_HAZARD_CHK_EN
      ,
      .hazard     (hazard)
`endif
   );

   mem_resp_pipe #(.DEPTH_LOG2(8), .LATENCY(2)) dut_l2 (
      .clk        (clk),
      .rst        (rst),
      .enable     (en2),
      .wr         (wr2),
      .addr       (addr2),
      .data_in    (din2),
      .data_out   (data_out2),
      .data_valid (data_valid2),
      .resp_addr  (resp_addr2),
      .busy       (busy2)
`ifdef MEM_RESP_HAZARD_CHK_EN
      ,
      .hazard     (hazard2)
`endif
   );

   typedef struct {
      logic        en;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic        exp_valid;
      logic [15:0] exp_data;
      logic [15:0] exp_raddr;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic e, input logic w, input logic [15:0] a,
                                  input logic [15:0] d, input logic ev, input logic [15:0] ed,
                                  input logic [15:0] ea, input logic eb);
      vec_t v;
      v.en = e; v.wr = w; v.addr = a; v.din = d;
      v.exp_valid = ev; v.exp_data = ed; v.exp_raddr = ea; v.exp_busy = eb;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive the main DUT inputs for the current cycle, then advance to just after the edge.
   task automatic applyStimulus(input logic e, input logic w, input logic [15:0] a,
                                input logic [15:0] d);
      enable  = e;
      wr      = w;
      addr    = a;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      logic [63:0] act;
      logic [63:0] exp;
      logic        saw_valid;

      rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
      en2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table: one row per cycle; outputs checked before the row's inputs are clocked in.
      for (int i = 0; i < 8; i++) addVec(1, 1, 16'(2 * i), 16'(i), 0, 0, 0, 0);
      addVec(1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0);
      addVec(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) addVec(0, 0, 0, 0, 0, 0, 0, 1);
      addVec(0, 0, 0, 0, 1, 16'hBEEF, 16'h0010, 1);
      addVec(0, 0, 0, 0, 0, 0, 0, 0);
      addVec(1, 0, 16'h0000, 0, 0, 0, 0, 0);
      for (int i = 1; i < 4; i++) addVec(1, 0, 16'(2 * i), 0, 0, 0, 0, 1);
      for (int i = 4; i < 8; i++) addVec(1, 0, 16'(2 * i), 0, 1, 16'(i - 4), 16'(2 * (i - 4)), 1);
      addVec(1, 1, 16'h0000, 16'h7777, 1, 16'h0004, 16'h0008, 1);
      for (int i = 5; i < 8; i++) addVec(0, 1, 16'h000E, 16'hFFFF, 1, 16'(i), 16'(2 * i), 1);
      addVec(1, 0, 16'h000E, 0, 0, 0, 0, 0);
      addVec(1, 0, 16'h0000, 0, 0, 0, 0, 1);
      addVec(0, 0, 0, 0, 0, 0, 0, 1);
      addVec(0, 0, 0, 0, 0, 0, 0, 1);
      addVec(0, 0, 0, 0, 1, 16'h0007, 16'h000E, 1);
      addVec(0, 0, 0, 0, 1, 16'h7777, 16'h0000, 1);
      addVec(0, 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         act = {29'd0, data_valid, data_out, resp_addr, busy};
         exp = {29'd0, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_raddr, vecs[i].exp_busy};
`ifdef MEM_RESP_HAZARD_CHK_EN
         act[40] = hazard;
         exp[40] = 1'b0;
`endif
         checkOutput($sformatf("vec%0d", i), act, exp);
         applyStimulus(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
      end

      // Read in flight while a write hits the same word: snapshot returned.
      applyStimulus(1, 1, 16'h0020, 16'h1111);
      applyStimulus(1, 0, 16'h0020, 16'h0000);
      applyStimulus(1, 1, 16'h0020, 16'h2222);
`ifdef MEM_RESP_HAZARD_CHK_EN
      checkOutput("hazard_pulse", {63'd0, hazard}, 64'd1);
`endif
      checkOutput("snap_no_valid_early", {63'd0, data_valid}, 64'd0);
      idle(1);
`ifdef MEM_RESP_HAZARD_CHK_EN
      checkOutput("hazard_one_cycle", {63'd0, hazard}, 64'd0);
`endif
      idle(1);
      checkOutput("snap_return", {31'd0, data_valid, data_out, resp_addr},
                  {31'd0, 1'b1, 16'h1111, 16'h0020});
      applyStimulus(1, 0, 16'h0020, 16'h0000);
      idle(3);
      checkOutput("after_write_return", {31'd0, data_valid, data_out, resp_addr},
                  {31'd0, 1'b1, 16'h2222, 16'h0020});
      idle(1);
      checkOutput("after_write_idle", {63'd0, data_valid}, 64'd0);

      // Reset two cycles after a read accept discards it; enable ignored during reset.
      applyStimulus(1, 1, 16'h0040, 16'h4444);
      applyStimulus(1, 0, 16'h0040, 16'h0000);
      idle(1);
      rst = 1'b1;
      applyStimulus(1, 1, 16'h0040, 16'hDEAD);
      rst = 1'b0;
      checkOutput("rst_clears", {30'd0, busy, data_valid, data_out, resp_addr}, 64'd0);
      saw_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         saw_valid = saw_valid | data_valid;
         idle(1);
      end
      checkOutput("rst_discards_read", {63'd0, saw_valid}, 64'd0);
      applyStimulus(1, 0, 16'h0040, 16'h0000);
      idle(3);
      checkOutput("storage_survives_rst", {31'd0, data_valid, data_out, resp_addr},
                  {31'd0, 1'b1, 16'h4444, 16'h0040});

      // Aliasing: 0x0202 and 0x0002 map to the same word.
      applyStimulus(1, 1, 16'h0202, 16'hA5A5);
      applyStimulus(1, 0, 16'h0002, 16'h0000);
      idle(3);
      checkOutput("alias_return", {31'd0, data_valid, data_out, resp_addr},
                  {31'd0, 1'b1, 16'hA5A5, 16'h0002});
      idle(1);

      // LATENCY=2 instance: read returns exactly two cycles after accept.
      en2 = 1'b1; wr2 = 1'b1; addr2 = 16'h0006; din2 = 16'h1234;
      idle(1);
      wr2 = 1'b0; din2 = 16'h0000;
      idle(1);
      en2 = 1'b0;
      checkOutput("l2_cycle1", {62'd0, data_valid2, busy2}, {62'd0, 1'b0, 1'b1});
      idle(1);
      checkOutput("l2_return", {30'd0, data_valid2, busy2, data_out2, resp_addr2},
                  {30'd0, 1'b1, 1'b1, 16'h1234, 16'h0006});
      idle(1);
      checkOutput("l2_done", {62'd0, data_valid2, busy2}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
